// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and default widths for the IF/LS memory port arbiter.
package mem_arb_pkg;

  localparam int unsigned AWIDTH_DEF = 32;
  localparam int unsigned DWIDTH_DEF = 32;

  // Transaction sequencing: accept -> drive memory request -> await response
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

  // Requester identity, used both for the current grant and round-robin history
  typedef enum logic {
    GNT_IF = 1'b0,
    GNT_LS = 1'b1
  } grant_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of fetch, load/store and memory-side handshake signals.
// slave: arbiter view. master: environment view (requesters and memory).
interface mem_port_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int unsigned AWIDTH = AWIDTH_DEF,
  parameter int unsigned DWIDTH = DWIDTH_DEF
);

  // Fetch requester
  logic                  if_req_valid;
  logic [AWIDTH-1:0]     if_req_addr;
  logic                  if_req_ready;
  logic                  if_rsp_valid;
  logic [DWIDTH-1:0]     if_rsp_data;

  // Load/store requester
  logic                  ls_req_valid;
  logic [AWIDTH-1:0]     ls_req_addr;
  logic                  ls_req_we;
  logic [DWIDTH-1:0]     ls_req_wdata;
  logic [DWIDTH/8-1:0]   ls_req_wmask;
  logic                  ls_req_ready;
  logic                  ls_rsp_valid;
  logic [DWIDTH-1:0]     ls_rsp_data;

  // Memory port
  logic                  mem_req_valid;
  logic [AWIDTH-1:0]     mem_req_addr;
  logic                  mem_req_we;
  logic [DWIDTH-1:0]     mem_req_wdata;
  logic [DWIDTH/8-1:0]   mem_req_wmask;
  logic                  mem_req_ready;
  logic                  mem_rsp_valid;
  logic [DWIDTH-1:0]     mem_rsp_data;

  modport slave (
    input  if_req_valid, if_req_addr,
    output if_req_ready, if_rsp_valid, if_rsp_data,
    input  ls_req_valid, ls_req_addr, ls_req_we, ls_req_wdata, ls_req_wmask,
    output ls_req_ready, ls_rsp_valid, ls_rsp_data,
    output mem_req_valid, mem_req_addr, mem_req_we, mem_req_wdata, mem_req_wmask,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_data
  );

  modport master (
    output if_req_valid, if_req_addr,
    input  if_req_ready, if_rsp_valid, if_rsp_data,
    output ls_req_valid, ls_req_addr, ls_req_we, ls_req_wdata, ls_req_wmask,
    input  ls_req_ready, ls_rsp_valid, ls_rsp_data,
    input  mem_req_valid, mem_req_addr, mem_req_we, mem_req_wdata, mem_req_wmask,
    output mem_req_ready, mem_rsp_valid, mem_rsp_data
  );

endinterface

// File: rtl/mem_port_arbiter_rr_arbiter2.sv
// Two-input round-robin grant. History only advances when a grant is taken.
module rr_arbiter2
  import mem_arb_pkg::*;
(
  input  logic   clock,
  input  logic   reset,
  input  logic   i_req_if,
  input  logic   i_req_ls,
  input  logic   i_en,
  output logic   o_any,
  output grant_e o_grant
);

  grant_e r_last;

  // Pick a winner: sole requester wins, otherwise the one not served last
  always_comb begin
    o_any   = i_req_if | i_req_ls;
    o_grant = GNT_IF;
    if (i_req_if && i_req_ls) begin
      o_grant = (r_last == GNT_IF) ? GNT_LS : GNT_IF;
    end else if (i_req_ls) begin
      o_grant = GNT_LS;
    end
  end

  // Remember the last granted requester; reset history favours LS next
  always_ff @(posedge clock) begin
    if (reset) begin
      r_last <= GNT_IF;
    end else if (i_en && o_any) begin
      r_last <= o_grant;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and load/store, one transaction at a time.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned AWIDTH = AWIDTH_DEF,
  parameter int unsigned DWIDTH = DWIDTH_DEF
)(
  input  logic                clock,
  input  logic                reset,
  mem_port_arbiter_if.slave   bus,
  output logic                err
);

  localparam int unsigned MWIDTH = DWIDTH / 8;

  state_e              r_state;
  state_e              w_next;
  logic                w_accept;
  logic                w_any;
  grant_e              w_grant;
  grant_e              r_gnt;

  logic [AWIDTH-1:0]   r_addr;
  logic                r_we;
  logic [DWIDTH-1:0]   r_wdata;
  logic [MWIDTH-1:0]   r_wmask;

  logic                r_if_rsp_valid;
  logic [DWIDTH-1:0]   r_if_rsp_data;
  logic                r_ls_rsp_valid;
  logic [DWIDTH-1:0]   r_ls_rsp_data;
  logic                r_err;

  logic                w_rsp_take;
  logic                w_rsp_stray;

  rr_arbiter2 u_rr (
    .clock    (clock),
    .reset    (reset),
    .i_req_if (bus.if_req_valid),
    .i_req_ls (bus.ls_req_valid),
    .i_en     (w_accept),
    .o_any    (w_any),
    .o_grant  (w_grant)
  );

  assign w_rsp_take  = (r_state == ST_WAIT) && bus.mem_rsp_valid;
  assign w_rsp_stray = (r_state != ST_WAIT) && bus.mem_rsp_valid;

  // Next state and accept decision; accept is suppressed while reset is held
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_any && !reset) begin
          w_accept = 1'b1;
          w_next   = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (bus.mem_req_ready) w_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (bus.mem_rsp_valid) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clock) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // Capture the granted request; fetches are forced to plain reads
  always_ff @(posedge clock) begin
    if (reset) begin
      r_gnt   <= GNT_IF;
      r_addr  <= '0;
      r_we    <= 1'b0;
      r_wdata <= '0;
      r_wmask <= '0;
    end else if (w_accept) begin
      r_gnt <= w_grant;
      if (w_grant == GNT_LS) begin
        r_addr  <= bus.ls_req_addr;
        r_we    <= bus.ls_req_we;
        r_wdata <= bus.ls_req_wdata;
        r_wmask <= bus.ls_req_wmask;
      end else begin
        r_addr  <= bus.if_req_addr;
        r_we    <= 1'b0;
        r_wdata <= '0;
        r_wmask <= '0;
      end
    end
  end

  // Route the memory response to the granted requester as a one-cycle pulse
  always_ff @(posedge clock) begin
    if (reset) begin
      r_if_rsp_valid <= 1'b0;
      r_if_rsp_data  <= '0;
      r_ls_rsp_valid <= 1'b0;
      r_ls_rsp_data  <= '0;
    end else begin
      r_if_rsp_valid <= w_rsp_take && (r_gnt == GNT_IF);
      r_ls_rsp_valid <= w_rsp_take && (r_gnt == GNT_LS);
      if (w_rsp_take && (r_gnt == GNT_IF)) r_if_rsp_data <= bus.mem_rsp_data;
      if (w_rsp_take && (r_gnt == GNT_LS)) r_ls_rsp_data <= r_we ? '0 : bus.mem_rsp_data;
    end
  end

  // Sticky flag for responses arriving with nothing outstanding
  always_ff @(posedge clock) begin
    if (reset)            r_err <= 1'b0;
    else if (w_rsp_stray) r_err <= 1'b1;
  end

  assign bus.if_req_ready  = w_accept && (w_grant == GNT_IF);
  assign bus.ls_req_ready  = w_accept && (w_grant == GNT_LS);
  assign bus.if_rsp_valid  = r_if_rsp_valid;
  assign bus.if_rsp_data   = r_if_rsp_data;
  assign bus.ls_rsp_valid  = r_ls_rsp_valid;
  assign bus.ls_rsp_data   = r_ls_rsp_data;
  assign bus.mem_req_valid = (r_state == ST_ISSUE);
  assign bus.mem_req_addr  = r_addr;
  assign bus.mem_req_we    = r_we;
  assign bus.mem_req_wdata = r_wdata;
  assign bus.mem_req_wmask = r_wmask;
  assign err               = r_err;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed plus randomized bench for mem_port_arbiter; the bench plays both
// requesters and a sparse word memory, predicting grants from the round-robin rule.
module tb_mem_port_arbiter;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic err;

  mem_port_arbiter_if #(.AWIDTH(32), .DWIDTH(32)) bus ();

  mem_port_arbiter #(.AWIDTH(32), .DWIDTH(32)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus),
    .err   (err)
  );

  always #5 clock = ~clock;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  // Reference state: who was served last (0 = IF, 1 = LS), error flag, memory
  bit          m_last = 1'b0;
  bit          m_err  = 1'b0;
  logic [31:0] mem_model [logic [31:0]];

  function automatic logic [31:0] mem_read(input logic [31:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return {a[15:0], ~a[15:0]};
  endfunction

  function automatic logic [31:0] byte_mask(input logic [3:0] wm);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{wm[i]}};
    return m;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    bus.if_req_valid  = 1'b0;
    bus.if_req_addr   = '0;
    bus.ls_req_valid  = 1'b0;
    bus.ls_req_addr   = '0;
    bus.ls_req_we     = 1'b0;
    bus.ls_req_wdata  = '0;
    bus.ls_req_wmask  = '0;
    bus.mem_req_ready = 1'b0;
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rsp_data  = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset  = 1'b0;
    m_last = 1'b0;
    m_err  = 1'b0;
  endtask

  task automatic check_quiet(input string tag);
    #1;
    chk({tag, ".if_ready"},  bus.if_req_ready,  0);
    chk({tag, ".ls_ready"},  bus.ls_req_ready,  0);
    chk({tag, ".if_rsp_v"},  bus.if_rsp_valid,  0);
    chk({tag, ".ls_rsp_v"},  bus.ls_rsp_valid,  0);
    chk({tag, ".if_data"},   bus.if_rsp_data,   0);
    chk({tag, ".ls_data"},   bus.ls_rsp_data,   0);
    chk({tag, ".mreq_v"},    bus.mem_req_valid, 0);
    chk({tag, ".mreq_addr"}, bus.mem_req_addr,  0);
    chk({tag, ".mreq_we"},   bus.mem_req_we,    0);
    chk({tag, ".mreq_wd"},   bus.mem_req_wdata, 0);
    chk({tag, ".mreq_wm"},   bus.mem_req_wmask, 0);
    chk({tag, ".err"},       err,               m_err);
  endtask

  // One full transaction, entered in an IDLE cycle; returns in the response cycle.
  // The losing requester keeps its valid asserted throughout.
  task automatic run_txn(input string tag, input bit ifv, input bit lsv,
                         input logic [31:0] ia, input logic [31:0] la, input bit we,
                         input logic [31:0] wd, input logic [3:0] wm,
                         input int unsigned rdy_dly, input int unsigned rsp_dly);
    bit          g;
    logic [31:0] ea, ewd, rd, erd, bm;
    logic        ewe;
    logic [3:0]  ewm;
    bus.if_req_valid  = ifv;
    bus.if_req_addr   = ia;
    bus.ls_req_valid  = lsv;
    bus.ls_req_addr   = la;
    bus.ls_req_we     = we;
    bus.ls_req_wdata  = wd;
    bus.ls_req_wmask  = wm;
    bus.mem_req_ready = 1'b0;
    bus.mem_rsp_valid = 1'b0;
    #1;
    g = (ifv && lsv) ? ~m_last : lsv;
    chk({tag, ".if_ready"}, bus.if_req_ready, (g == 1'b0));
    chk({tag, ".ls_ready"}, bus.ls_req_ready, (g == 1'b1));
    m_last = g;
    if (g) begin
      ea = la; ewe = we; ewd = wd; ewm = wm;
    end else begin
      ea = ia; ewe = 1'b0; ewd = '0; ewm = '0;
    end
    tick();
    if (g) bus.ls_req_valid = 1'b0;
    else   bus.if_req_valid = 1'b0;
    for (int unsigned k = 0; k <= rdy_dly; k++) begin
      bus.mem_req_ready = (k == rdy_dly);
      #1;
      chk({tag, ".mreq_v"},    bus.mem_req_valid, 1);
      chk({tag, ".mreq_addr"}, bus.mem_req_addr,  ea);
      chk({tag, ".mreq_we"},   bus.mem_req_we,    ewe);
      chk({tag, ".mreq_wd"},   bus.mem_req_wdata, ewd);
      chk({tag, ".mreq_wm"},   bus.mem_req_wmask, ewm);
      if (k == 0) begin
        chk({tag, ".busy_if_ready"}, bus.if_req_ready, 0);
        chk({tag, ".busy_ls_ready"}, bus.ls_req_ready, 0);
      end
      tick();
    end
    bus.mem_req_ready = 1'b0;
    rd = mem_read(ea);
    bm = byte_mask(ewm);
    if (ewe) mem_model[ea] = (rd & ~bm) | (ewd & bm);
    erd = ewe ? 32'h0 : rd;
    for (int unsigned k = 0; k <= rsp_dly; k++) begin
      bus.mem_rsp_valid = (k == rsp_dly);
      bus.mem_rsp_data  = (k == rsp_dly) ? rd : $urandom;
      #1;
      if (k == 0) chk({tag, ".wait_mreq_v"}, bus.mem_req_valid, 0);
      chk({tag, ".early_if_rsp"}, bus.if_rsp_valid, 0);
      chk({tag, ".early_ls_rsp"}, bus.ls_rsp_valid, 0);
      tick();
    end
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rsp_data  = '0;
    chk({tag, ".if_rsp_v"}, bus.if_rsp_valid, (g == 1'b0));
    chk({tag, ".ls_rsp_v"}, bus.ls_rsp_valid, (g == 1'b1));
    if (g) chk({tag, ".ls_data"}, bus.ls_rsp_data, erd);
    else   chk({tag, ".if_data"}, bus.if_rsp_data, erd);
    chk({tag, ".err"}, err, m_err);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout checks=%0d passed=%0d", n_checks, n_pass);
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] ra, rl, rw;
    logic [1:0]  v;

    // Reset state
    do_reset();
    check_quiet("reset");

    // Fetch alone, immediate memory, minimum latency
    mem_model[32'h0100_0000] = 32'h0000_0013;
    run_txn("if_alone", 1'b1, 1'b0, 32'h0100_0000, 32'h0, 1'b0, 32'h0, 4'h0, 0, 0);
    idle_inputs();
    tick();

    // Simultaneous requests from reset: LS, IF, LS, IF back to back
    do_reset();
    for (int i = 0; i < 4; i++) begin
      run_txn("alternate", 1'b1, 1'b1, 32'h0000_1000 + 32'(i * 4),
              32'h0000_2000 + 32'(i * 4), 1'b0, 32'h0, 4'h0, 0, 0);
    end
    idle_inputs();
    tick();

    // Store held off by memory for three cycles, then read back
    run_txn("store", 1'b0, 1'b1, 32'h0, 32'h0100_0010, 1'b1, 32'hDEAD_BEEF, 4'hF, 3, 0);
    run_txn("load_back", 1'b0, 1'b1, 32'h0, 32'h0100_0010, 1'b0, 32'h0, 4'h0, 0, 1);
    idle_inputs();
    tick();

    // Stray response while idle sets the sticky error
    do_reset();
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_data  = 32'h1234_5678;
    tick();
    bus.mem_rsp_valid = 1'b0;
    m_err = 1'b1;
    chk("stray.err", err, 1);
    chk("stray.if_rsp_v", bus.if_rsp_valid, 0);
    chk("stray.ls_rsp_v", bus.ls_rsp_valid, 0);
    repeat (3) tick();
    chk("stray.err_held", err, 1);
    run_txn("after_stray", 1'b1, 1'b0, 32'h0000_0040, 32'h0, 1'b0, 32'h0, 4'h0, 1, 1);
    idle_inputs();
    tick();
    do_reset();
    chk("stray.err_cleared", err, 0);

    // Reset while waiting for the response abandons the transaction
    bus.if_req_valid = 1'b1;
    bus.if_req_addr  = 32'h0000_0080;
    #1;
    chk("rst_wait.accept", bus.if_req_ready, 1);
    tick();
    bus.if_req_valid  = 1'b0;
    bus.mem_req_ready = 1'b1;
    tick();
    bus.mem_req_ready = 1'b0;
    reset = 1'b1;
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_data  = 32'hFFFF_FFFF;
    tick();
    reset = 1'b0;
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rsp_data  = '0;
    m_last = 1'b0;
    m_err  = 1'b0;
    check_quiet("rst_wait");
    tick();
    chk("rst_wait.no_if_rsp", bus.if_rsp_valid, 0);
    chk("rst_wait.no_ls_rsp", bus.ls_rsp_valid, 0);
    run_txn("rst_wait.next", 1'b1, 1'b1, 32'h0000_0080, 32'h0100_0000, 1'b0, 32'h0, 4'h0, 0, 0);
    idle_inputs();
    tick();

    // Randomized traffic over a small address pool so stores and loads collide
    for (int i = 0; i < 40; i++) begin
      v  = 2'($urandom_range(1, 3));
      ra = 32'h0100_0000 + (32'($urandom_range(0, 7)) << 2);
      rl = 32'h0100_0000 + (32'($urandom_range(0, 7)) << 2);
      rw = $urandom;
      run_txn("random", v[0], v[1], ra, rl, 1'($urandom_range(0, 1)), rw,
              4'($urandom_range(0, 15)), $urandom_range(0, 3), $urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) begin
        idle_inputs();
        tick();
      end
    end
    idle_inputs();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares a single memory port between the fetch stage (IF) and the load/store stage (LS) of the five-stage RISC-V core. Accepts one request at a time from either requester, arbitrates round-robin, drives the registered request to the memory port, waits for the response and returns it to the granted requester. Sits between the `pd` pipeline stages and the unified memory model, replacing separate instruction and data ports.

## Interface
- `AWIDTH`, 32, address width in bits
- `DWIDTH`, 32, data width in bits; write mask is `DWIDTH/8` bits

- `clock`  in  1  core clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high reset
- `if_req_valid`  in  1  fetch request pending (read only)
- `if_req_addr`  in  AWIDTH  fetch address
- `if_req_ready`  out  1  fetch request accepted this cycle
- `if_rsp_valid`  out  1  one-cycle pulse, fetch data valid
- `if_rsp_data`  out  DWIDTH  fetched word
- `ls_req_valid`  in  1  load/store request pending
- `ls_req_addr`  in  AWIDTH  load/store address
- `ls_req_we`  in  1  1 = store, 0 = load
- `ls_req_wdata`  in  DWIDTH  store data
- `ls_req_wmask`  in  DWIDTH/8  store byte enables
- `ls_req_ready`  out  1  load/store request accepted this cycle
- `ls_rsp_valid`  out  1  one-cycle pulse, load data or store ack
- `ls_rsp_data`  out  DWIDTH  load data; 0 for store ack
- `mem_req_valid`  out  1  request to memory
- `mem_req_addr`, `mem_req_we`, `mem_req_wdata`, `mem_req_wmask`  out  AWIDTH/1/DWIDTH/DWIDTH/8  registered request fields
- `mem_req_ready`  in  1  memory accepts request
- `mem_rsp_valid`  in  1  memory response (reads and writes)
- `mem_rsp_data`  in  DWIDTH  read data
- `err`  out  1  sticky protocol error

## Operation
- FSM states: IDLE, ISSUE, WAIT. Reset -> IDLE.
- IDLE: if any `*_req_valid`, grant one, assert its `*_req_ready` (combinational, same cycle), latch addr/we/wdata/wmask and grant ID, go ISSUE. Fetch requests latch `we=0`, `wmask=0`, `wdata=0`.
- Arbitration: round-robin on `last_grant`; reset value = IF, so first simultaneous request goes to LS. Single requester always wins. `last_grant` updates only on grant.
- ISSUE: `mem_req_valid=1`, fields stable; on `mem_req_ready` go WAIT.
- WAIT: on `mem_rsp_valid` register response to granted requester (`*_rsp_valid` pulse next cycle, data = `mem_rsp_data` for reads, 0 for stores), go IDLE.
- At most one outstanding transaction; `*_req_ready` is 0 outside IDLE.
- `mem_rsp_valid` in IDLE or ISSUE: ignored, sets `err`. `err` clears only on reset.
- Reset mid-transaction: abandon it, no response pulse, IDLE next cycle.

## Timing
- Reset values: all `*_ready`, `*_rsp_valid`, `mem_req_valid`, `err` = 0; data/addr outputs = 0; `last_grant` = IF.
- Accept at cycle N -> `mem_req_valid` at N+1; with `mem_req_ready` at N+1 and `mem_rsp_valid` at N+2 -> `*_rsp_valid` at N+3. Minimum 3-cycle latency.
- Response pulse cycle is an IDLE cycle: a new request may be accepted in the same cycle as the previous `*_rsp_valid` pulse (back-to-back issue every 3 cycles).
- `mem_req_*` held constant while `mem_req_valid & !mem_req_ready`.
- Exactly one `*_rsp_valid` pulse per accepted request; never both in one cycle.

## Structure
- Package `mem_arb_pkg`: state enum (IDLE/ISSUE/WAIT), grant enum (GNT_IF/GNT_LS), default width constants.
- Sub-module `rr_arbiter2`: 2-input round-robin grant with `last_grant` register, enable on accept.

## Test plan
- IF alone, addr 0x0100_0000, memory ready immediately, rsp 0x0000_0013 at N+2 -> `if_rsp_valid` at N+3, data 0x0000_0013, `ls_rsp_valid` stays 0.
- IF and LS valid together from reset -> LS granted first, IF next; continuous both-valid -> grants alternate LS, IF, LS, IF.
- LS store addr 0x0100_0010, wdata 0xDEADBEEF, wmask 0xF, `mem_req_ready` low 3 cycles -> `mem_req_*` stable for all 4 cycles, `ls_rsp_valid` with data 0 after ack.
- `mem_rsp_valid` asserted while IDLE -> `err`=1, no response pulses, `err` held until reset.
- `reset` asserted in WAIT -> next cycle IDLE, all outputs 0, no `*_rsp_valid`; following request completes normally.
